rd_req_fsm: RTL and testbench
=============================

# rd_req_fsm

Read-side counterpart to the register-file write path. It accepts a read request and address from the instruction decoder, issues a read strobe to the register file, and waits the file's fixed read latency. It then returns the data with a one-cycle valid pulse. It tracks in-flight decoder writes and stalls any read whose address matches a write that has not yet committed (read-after-write), so the read always returns the newly written value.

## Interface
- `DATA_W`, 8, register data width
- `ADDR_W`, 3, register address width
- `RD_LAT`, 1, cycles from `rf_rd_en` to valid `rf_rd_data`; legal 1..7

- `clk`  in  1  clock; all state updates on rising edge
- `rst_b`  in  1  reset; asynchronous, active-low
- `rd_req`  in  1  decoder read request; sampled only when `rd_busy`=0
- `rd_addr`  in  ADDR_W  read address, sampled with `rd_req`
- `rd_busy`  out  1  combinational; 1 whenever state is not IDLE
- `wr_req`  in  1  decoder write request, the same strobe fed to the write path
- `wr_addr`  in  ADDR_W  write address, valid with `wr_req`
- `rf_rd_en`  out  1  register-file read strobe
- `rf_rd_addr`  out  ADDR_W  register-file read address
- `rf_rd_data`  in  DATA_W  register-file read data
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid
- `rd_data`  out  DATA_W  returned data; holds its value until the next capture

## Operation
- **Write tracker.** Two-stage shadow pipe: `wp1`/`wp1_addr` ← `wr_req`/`wr_addr`, then `wp2` ← `wp1`.
  - The register-file write strobe fires in the `wp2` cycle.
  - The write commits at the end of that cycle.
- **Hazard.** `hz` = (`wr_req` && `wr_addr`==A) || (`wp1` && `wp1_addr`==A), where A is the pending read address.
  - A `wp2` match alone is not a hazard: that write commits before ISSUE.
- **States.**
  - IDLE: on `rd_req`, latch `rd_addr` into A. Go to HAZ if `hz` (evaluated with A=`rd_addr`), else ISSUE.
  - HAZ: stay while `hz`; otherwise go to ISSUE. Repeated matching writes stall the read indefinitely; this is accepted.
  - ISSUE: `rf_rd_en`=1 and `rf_rd_addr`=A for exactly one cycle. Load the latency counter with RD_LAT and go to WAIT.
  - WAIT: decrement the counter. In the cycle the counter equals 1, capture `rf_rd_data` into `rd_data` and go to RESP.
  - RESP: `rd_valid`=1 for one cycle, then go to IDLE.
- **Flow rules.**
  - `rd_req` while busy is ignored, not queued.
  - Writes are never blocked by this block.
- **Outputs.** `rf_rd_en` and `rd_valid` are decoded from registered state. `rf_rd_addr` is the registered A.
- **Counter width.** 3 bits. RD_LAT outside 1..7 is unsupported.

## Timing
- Reset (asynchronous, any state): state=IDLE, `wp1`=`wp2`=0.
  - `rf_rd_en`=0, `rf_rd_addr`=0, `rd_valid`=0, `rd_data`=0, `rd_busy`=0.
  - A read in flight is dropped; no `rd_valid` is produced.
- No hazard, request accepted in cycle T:
  - ISSUE in T+1.
  - WAIT in T+2..T+1+RD_LAT.
  - RESP (`rd_valid`) in T+2+RD_LAT.
  - IDLE in T+3+RD_LAT, where a new request is accepted.
- Hazard from a matching `wr_req` in T: HAZ in T+1..T+2, ISSUE in T+3, RESP in T+4+RD_LAT (two-cycle penalty).
- Matching write one cycle earlier (in `wp1` at T): HAZ in T+1, ISSUE in T+2.
- Matching write two cycles earlier (in `wp2` at T): no stall.

## Structure
- Shared constants include holds:
  - state encodings (IDLE, HAZ, ISSUE, WAIT, RESP, 3-bit);
  - default `DATA_W` and `ADDR_W`, shared with the write path and register file.
- One sub-module, `wr_track`: the two-stage write shadow pipe with its address compare. Output `hz`; inputs are the address under test plus `wr_req`/`wr_addr`.
- The FSM, counter and data capture live in `rd_req_fsm`.

## Test plan
Register-file model with `RD_LAT`=1 unless stated; addr 3 holds 8'hA5.
1. Assert `rst_b`=0 mid-run → all outputs 0 asynchronously, and `rd_busy`=0.
2. `rd_req`, addr 3 at T → `rf_rd_en`=1 and `rf_rd_addr`=3 at T+1. `rd_valid`=1 with 8'hA5 at T+3. `rd_busy`=1 T+1..T+3.
3. `wr_req` addr 3 (data 8'h5A) and `rd_req` addr 3 both at T → `rf_rd_en` at T+3; `rd_valid` with 8'h5A at T+5.
4. `wr_req` addr 4 and `rd_req` addr 3 at T → no stall; 8'hA5 at T+3.
5. `RD_LAT`=3: `rd_req` addr 3 at T, second `rd_req` at T+2 → one `rd_valid` at T+5 only. The second request is ignored; a request at T+6 is accepted.
6. Reset pulse during WAIT → `rd_valid` is never asserted. A subsequent read of addr 3 returns 8'hA5 with normal latency.

Source files
------------

// File: rtl/rd_req_fsm_pkg.sv
// Shared constants for the register-file read path: FSM encodings and default widths.
// The write path and the register file use the same default widths.
package rd_req_fsm_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 3;
    localparam int unsigned CntW     = 3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHaz   = 3'd1,
        StIssue = 3'd2,
        StWait  = 3'd3,
        StResp  = 3'd4
    } state_e;

    // Latency counter load value; RD_LAT is restricted to 1..7.
    function automatic logic [CntW-1:0] lat_load(input int unsigned lat);
        return CntW'(lat);
    endfunction

endpackage

// File: rtl/rd_req_fsm_if.sv
// Decoder / register-file bundle seen by the read request FSM.
// The slave modport is the FSM's view; master is the decoder and register file.
interface rd_req_fsm_if
    import rd_req_fsm_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) ();

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_busy;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_commit;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  wr_req,
        input  wr_addr,
        input  rf_rd_data,
        output rd_busy,
        output wr_commit,
        output rf_rd_en,
        output rf_rd_addr,
        output rd_valid,
        output rd_data
    );

    modport master (
        output rd_req,
        output rd_addr,
        output wr_req,
        output wr_addr,
        output rf_rd_data,
        input  rd_busy,
        input  wr_commit,
        input  rf_rd_en,
        input  rf_rd_addr,
        input  rd_valid,
        input  rd_data
    );

endinterface

// File: rtl/rd_req_fsm_wr_track.sv
// Two-stage shadow of decoder writes with read-after-write hazard compare.
// A write sitting in the second stage commits this cycle, so it never raises a hazard.
module wr_track
    import rd_req_fsm_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [ADDR_W-1:0] test_addr_i,
    output logic              hz_o,
    output logic              wr_commit_o
);

    logic              wp1_q, wp1_d;
    logic [ADDR_W-1:0] wp1_addr_q, wp1_addr_d;
    logic              wp2_q, wp2_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp1_q      <= 1'b0;
            wp1_addr_q <= '0;
            wp2_q      <= 1'b0;
        end else begin
            wp1_q      <= wp1_d;
            wp1_addr_q <= wp1_addr_d;
            wp2_q      <= wp2_d;
        end
    end

    always_comb begin
        wp1_d      = wr_req_i;
        wp1_addr_d = wr_addr_i;
        wp2_d      = wp1_q;
    end

    always_comb begin
        hz_o = (wr_req_i && (wr_addr_i == test_addr_i)) ||
               (wp1_q && (wp1_addr_q == test_addr_i));
    end

    assign wr_commit_o = wp2_q;

endmodule

// File: rtl/rd_req_fsm.sv
// Read request FSM: accepts a decoder read, stalls on pending writes to the same address,
// strobes the register file, waits its fixed latency and returns the data with a valid pulse.
module rd_req_fsm
    import rd_req_fsm_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned RD_LAT = 1
) (
    input logic         clk_i,
    input logic         rst_ni,
    rd_req_fsm_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] test_addr;
    logic              hz;
    logic              wr_commit;

    // In IDLE the incoming address is checked so a hazard is caught on acceptance.
    assign test_addr = (state_q == StIdle) ? bus.rd_addr : addr_q;

    wr_track #(
        .ADDR_W (ADDR_W)
    ) u_wr_track (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_req_i    (bus.wr_req),
        .wr_addr_i   (bus.wr_addr),
        .test_addr_i (test_addr),
        .hz_o        (hz),
        .wr_commit_o (wr_commit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (bus.rd_req) begin
                    addr_d  = bus.rd_addr;
                    state_d = hz ? StHaz : StIssue;
                end
            end
            StHaz: begin
                if (!hz) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = lat_load(RD_LAT);
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    data_d  = bus.rf_rd_data;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.rd_busy    = (state_q != StIdle);
    assign bus.rf_rd_en   = (state_q == StIssue);
    assign bus.rf_rd_addr = addr_q;
    assign bus.rd_valid   = (state_q == StResp);
    assign bus.rd_data    = data_q;
    assign bus.wr_commit  = wr_commit;

endmodule

// File: tb/tb_rd_req_fsm.sv
// Directed bench for rd_req_fsm with RD_LAT=1 and RD_LAT=3 instances sharing one
// register-file model; inputs are driven just after each rising edge.
module tb_rd_req_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_req;
    logic [2:0] rd_addr;
    logic       wr_req;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       mem_init;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rd_req_fsm_if #(.DATA_W(8), .ADDR_W(3)) if1 ();
    rd_req_fsm_if #(.DATA_W(8), .ADDR_W(3)) if3 ();

    rd_req_fsm #(.DATA_W(8), .ADDR_W(3), .RD_LAT(1)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if1)
    );

    rd_req_fsm #(.DATA_W(8), .ADDR_W(3), .RD_LAT(3)) u_dut3 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if3)
    );

    // Register-file model: writes commit two cycles after wr_req; reads return data
    // RD_LAT cycles after the strobe, and a poison value when no read was strobed.
    logic [7:0] mem [8];
    logic       wp1, wp2;
    logic [2:0] wa1, wa2;
    logic [7:0] wd1, wd2;
    logic [7:0] p1;
    logic [7:0] p3 [3];

    always @(posedge clk) begin
        wp1 <= wr_req;
        wa1 <= wr_addr;
        wd1 <= wr_data;
        wp2 <= wp1;
        wa2 <= wa1;
        wd2 <= wd1;
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= (i == 3) ? 8'hA5 : 8'(8'h10 + i);
        end else if (wp2) begin
            mem[wa2] <= wd2;
        end
        p1    <= if1.rf_rd_en ? mem[if1.rf_rd_addr] : 8'hEE;
        p3[0] <= if3.rf_rd_en ? mem[if3.rf_rd_addr] : 8'hEE;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign if1.rd_req     = rd_req;
    assign if1.rd_addr    = rd_addr;
    assign if1.wr_req     = wr_req;
    assign if1.wr_addr    = wr_addr;
    assign if1.rf_rd_data = p1;
    assign if3.rd_req     = rd_req;
    assign if3.rd_addr    = rd_addr;
    assign if3.wr_req     = wr_req;
    assign if3.wr_addr    = wr_addr;
    assign if3.rf_rd_data = p3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if ({if1.rf_rd_en, if1.rf_rd_addr, if1.rd_valid, if1.rd_data, if1.rd_busy} !== 13'd0)
            $display("FAIL reset_outputs got %h exp 0", {if1.rf_rd_en, if1.rf_rd_addr, if1.rd_valid, if1.rd_data, if1.rd_busy}); else pass_cnt++;
        total_cnt++; if (if3.rd_busy !== 1'b0) $display("FAIL reset_busy3 got %b exp 0", if3.rd_busy); else pass_cnt++;
        idle(2);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        tick(); rd_req = 1'b1; rd_addr = 3'd3;
        total_cnt++; if (if1.rd_busy !== 1'b0) $display("FAIL basic_busy_t0 got %b exp 0", if1.rd_busy); else pass_cnt++;
        tick(); rd_req = 1'b0;
        total_cnt++; if (if1.rf_rd_en !== 1'b1) $display("FAIL basic_en_t1 got %b exp 1", if1.rf_rd_en); else pass_cnt++;
        total_cnt++; if (if1.rf_rd_addr !== 3'd3) $display("FAIL basic_addr_t1 got %0d exp 3", if1.rf_rd_addr); else pass_cnt++;
        total_cnt++; if (if1.rd_busy !== 1'b1) $display("FAIL basic_busy_t1 got %b exp 1", if1.rd_busy); else pass_cnt++;
        tick();
        total_cnt++; if ({if1.rf_rd_en, if1.rd_valid, if1.rd_busy} !== 3'b001)
            $display("FAIL basic_t2 got %b exp 001", {if1.rf_rd_en, if1.rd_valid, if1.rd_busy}); else pass_cnt++;
        tick();
        total_cnt++; if (if1.rd_valid !== 1'b1) $display("FAIL basic_valid_t3 got %b exp 1", if1.rd_valid); else pass_cnt++;
        total_cnt++; if (if1.rd_data !== 8'hA5) $display("FAIL basic_data_t3 got %h exp a5", if1.rd_data); else pass_cnt++;
        total_cnt++; if (if1.rd_busy !== 1'b1) $display("FAIL basic_busy_t3 got %b exp 1", if1.rd_busy); else pass_cnt++;
        tick();
        total_cnt++; if ({if1.rd_valid, if1.rd_busy} !== 2'b00)
            $display("FAIL basic_t4 got %b exp 00", {if1.rd_valid, if1.rd_busy}); else pass_cnt++;
        idle(6);
    endtask

    task automatic test_reset_async();
        tick(); rd_req = 1'b1; rd_addr = 3'd2;
        tick(); rd_req = 1'b0;
        total_cnt++; if (if1.rf_rd_en !== 1'b1) $display("FAIL arst_pre_en got %b exp 1", if1.rf_rd_en); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (if1.rf_rd_en !== 1'b0) $display("FAIL arst_en got %b exp 0", if1.rf_rd_en); else pass_cnt++;
        total_cnt++; if (if1.rf_rd_addr !== 3'd0) $display("FAIL arst_addr got %0d exp 0", if1.rf_rd_addr); else pass_cnt++;
        total_cnt++; if (if1.rd_data !== 8'h00) $display("FAIL arst_data got %h exp 00", if1.rd_data); else pass_cnt++;
        total_cnt++; if ({if1.rd_valid, if1.rd_busy, if3.rd_busy} !== 3'b000)
            $display("FAIL arst_flags got %b exp 000", {if1.rd_valid, if1.rd_busy, if3.rd_busy}); else pass_cnt++;
        tick(); rst_n = 1'b1;
        idle(8);
    endtask

    task automatic test_no_stall();
        tick(); wr_req = 1'b1; wr_addr = 3'd4; wr_data = 8'h44; rd_req = 1'b1; rd_addr = 3'd3;
        tick(); wr_req = 1'b0; rd_req = 1'b0;
        total_cnt++; if (if1.rf_rd_en !== 1'b1) $display("FAIL nostall_en_t1 got %b exp 1", if1.rf_rd_en); else pass_cnt++;
        idle(2);
        total_cnt++; if ({if1.rd_valid, if1.rd_data} !== {1'b1, 8'hA5})
            $display("FAIL nostall_t3 got %h exp 1a5", {if1.rd_valid, if1.rd_data}); else pass_cnt++;
        idle(6);
    endtask

    task automatic test_lat3();
        tick(); rd_req = 1'b1; rd_addr = 3'd3;
        tick(); rd_req = 1'b0;
        total_cnt++; if (if3.rf_rd_en !== 1'b1) $display("FAIL lat3_en_t1 got %b exp 1", if3.rf_rd_en); else pass_cnt++;
        tick(); rd_req = 1'b1; rd_addr = 3'd5;
        total_cnt++; if (if3.rd_valid !== 1'b0) $display("FAIL lat3_valid_t2 got %b exp 0", if3.rd_valid); else pass_cnt++;
        tick(); rd_req = 1'b0;
        total_cnt++; if ({if3.rd_valid, if3.rf_rd_en} !== 2'b00)
            $display("FAIL lat3_t3 got %b exp 00", {if3.rd_valid, if3.rf_rd_en}); else pass_cnt++;
        tick();
        total_cnt++; if (if3.rd_valid !== 1'b0) $display("FAIL lat3_valid_t4 got %b exp 0", if3.rd_valid); else pass_cnt++;
        tick();
        total_cnt++; if ({if3.rd_valid, if3.rd_data} !== {1'b1, 8'hA5})
            $display("FAIL lat3_t5 got %h exp 1a5", {if3.rd_valid, if3.rd_data}); else pass_cnt++;
        total_cnt++; if (if3.rf_rd_addr !== 3'd3) $display("FAIL lat3_addr_kept got %0d exp 3", if3.rf_rd_addr); else pass_cnt++;
        tick(); rd_req = 1'b1; rd_addr = 3'd5;
        total_cnt++; if ({if3.rd_valid, if3.rd_busy} !== 2'b00)
            $display("FAIL lat3_t6 got %b exp 00", {if3.rd_valid, if3.rd_busy}); else pass_cnt++;
        tick(); rd_req = 1'b0;
        total_cnt++; if ({if3.rf_rd_en, if3.rf_rd_addr} !== {1'b1, 3'd5})
            $display("FAIL lat3_second_issue got %b exp 1101", {if3.rf_rd_en, if3.rf_rd_addr}); else pass_cnt++;
        idle(4);
        total_cnt++; if ({if3.rd_valid, if3.rd_data} !== {1'b1, 8'h15})
            $display("FAIL lat3_second_data got %h exp 115", {if3.rd_valid, if3.rd_data}); else pass_cnt++;
        idle(6);
    endtask

    task automatic test_reset_wait();
        tick(); rd_req = 1'b1; rd_addr = 3'd3;
        tick(); rd_req = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if ({if1.rd_busy, if3.rd_busy} !== 2'b00)
            $display("FAIL rstwait_busy got %b exp 00", {if1.rd_busy, if3.rd_busy}); else pass_cnt++;
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++; if ({if1.rd_valid, if3.rd_valid} !== 2'b00)
                $display("FAIL rstwait_no_valid cyc %0d got %b exp 00", i, {if1.rd_valid, if3.rd_valid}); else pass_cnt++;
        end
        tick(); rd_req = 1'b1; rd_addr = 3'd3;
        tick(); rd_req = 1'b0;
        idle(2);
        total_cnt++; if ({if1.rd_valid, if1.rd_data} !== {1'b1, 8'hA5})
            $display("FAIL rstwait_reread1 got %h exp 1a5", {if1.rd_valid, if1.rd_data}); else pass_cnt++;
        idle(2);
        total_cnt++; if ({if3.rd_valid, if3.rd_data} !== {1'b1, 8'hA5})
            $display("FAIL rstwait_reread3 got %h exp 1a5", {if3.rd_valid, if3.rd_data}); else pass_cnt++;
        idle(6);
    endtask

    task automatic test_hazard();
        tick(); wr_req = 1'b1; wr_addr = 3'd3; wr_data = 8'h5A; rd_req = 1'b1; rd_addr = 3'd3;
        tick(); wr_req = 1'b0; rd_req = 1'b0;
        total_cnt++; if ({if1.rf_rd_en, if1.rd_busy} !== 2'b01)
            $display("FAIL haz_t1 got %b exp 01", {if1.rf_rd_en, if1.rd_busy}); else pass_cnt++;
        tick();
        total_cnt++; if (if1.rf_rd_en !== 1'b0) $display("FAIL haz_en_t2 got %b exp 0", if1.rf_rd_en); else pass_cnt++;
        total_cnt++; if (if1.wr_commit !== 1'b1) $display("FAIL haz_commit_t2 got %b exp 1", if1.wr_commit); else pass_cnt++;
        tick();
        total_cnt++; if ({if1.rf_rd_en, if1.rf_rd_addr} !== {1'b1, 3'd3})
            $display("FAIL haz_issue_t3 got %b exp 1011", {if1.rf_rd_en, if1.rf_rd_addr}); else pass_cnt++;
        tick();
        total_cnt++; if (if1.rd_valid !== 1'b0) $display("FAIL haz_valid_t4 got %b exp 0", if1.rd_valid); else pass_cnt++;
        tick();
        total_cnt++; if ({if1.rd_valid, if1.rd_data} !== {1'b1, 8'h5A})
            $display("FAIL haz_t5 got %h exp 15a", {if1.rd_valid, if1.rd_data}); else pass_cnt++;
        idle(6);
    endtask

    task automatic test_wp1_hazard();
        tick(); wr_req = 1'b1; wr_addr = 3'd6; wr_data = 8'h66;
        tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 3'd6;
        tick(); rd_req = 1'b0;
        total_cnt++; if ({if1.rf_rd_en, if1.rd_busy} !== 2'b01)
            $display("FAIL wp1_t1 got %b exp 01", {if1.rf_rd_en, if1.rd_busy}); else pass_cnt++;
        tick();
        total_cnt++; if (if1.rf_rd_en !== 1'b1) $display("FAIL wp1_issue_t2 got %b exp 1", if1.rf_rd_en); else pass_cnt++;
        idle(2);
        total_cnt++; if ({if1.rd_valid, if1.rd_data} !== {1'b1, 8'h66})
            $display("FAIL wp1_t4 got %h exp 166", {if1.rd_valid, if1.rd_data}); else pass_cnt++;
        idle(6);
    endtask

    task automatic test_wp2_no_stall();
        tick(); wr_req = 1'b1; wr_addr = 3'd7; wr_data = 8'h77;
        tick(); wr_req = 1'b0;
        tick(); rd_req = 1'b1; rd_addr = 3'd7;
        total_cnt++; if (if1.wr_commit !== 1'b1) $display("FAIL wp2_commit got %b exp 1", if1.wr_commit); else pass_cnt++;
        tick(); rd_req = 1'b0;
        total_cnt++; if (if1.rf_rd_en !== 1'b1) $display("FAIL wp2_issue_t1 got %b exp 1", if1.rf_rd_en); else pass_cnt++;
        idle(2);
        total_cnt++; if ({if1.rd_valid, if1.rd_data} !== {1'b1, 8'h77})
            $display("FAIL wp2_t3 got %h exp 177", {if1.rd_valid, if1.rd_data}); else pass_cnt++;
        idle(6);
    endtask

    initial begin
        rst_n    = 1'b0;
        mem_init = 1'b1;
        rd_req   = 1'b0;
        rd_addr  = 3'd0;
        wr_req   = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'h00;
        test_reset();
        test_basic();
        test_reset_async();
        test_no_stall();
        test_lat3();
        test_reset_wait();
        test_hazard();
        test_wp1_hazard();
        test_wp2_no_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
